// File: rtl/bus_sequencer_if.sv
// Data-bus source controller signal bundle: instruction handshake, operand levels,
// RAM read port and the registered result bus.
interface bus_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [DATA_W-1:0] insn;
    logic              insn_valid;
    logic              insn_ready;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] level_A;
    logic [DATA_W-1:0] level_C;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] bus_data;
    logic              bus_valid;
    logic              bus_err;

    // master: the sequencer, which drives the bus and the RAM request
    modport master (
        input  insn, insn_valid, alu_result, level_A, level_C, mem_ack, mem_rdata,
        output insn_ready, mem_req, mem_addr, bus_data, bus_valid, bus_err
    );

    // slave: the core / RAM side feeding the sequencer
    modport slave (
        output insn, insn_valid, alu_result, level_A, level_C, mem_ack, mem_rdata,
        input  insn_ready, mem_req, mem_addr, bus_data, bus_valid, bus_err
    );
endinterface

// File: rtl/bus_sequencer.sv
// Decodes the opcode nibble of each accepted instruction and drives the selected
// source onto a registered data bus; RAM reads stall the core until ack or timeout.
module bus_sequencer #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    bus_sequencer_if.master bus
);
    localparam int HALF  = DATA_W / 2;
    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic [DATA_W-1:0] bus_data_reg;
    logic              bus_valid_reg;
    logic              bus_err_reg;
    logic              mem_req_reg;
    logic [ADDR_W-1:0] mem_addr_reg;

    logic [3:0]        opcode;
    logic              src_valid;
    logic              is_ram;
    logic [DATA_W-1:0] src_data;

    assign opcode = bus.insn[DATA_W-1:DATA_W-4];

    // Overlapping patterns: the first matching item wins, so SC must precede ALU.
    always_comb begin
        src_valid = 1'b0;
        is_ram    = 1'b0;
        src_data  = '0;
        casez (opcode)
            4'b0000: begin
                src_valid = 1'b1;
                src_data  = bus.level_C;
            end
            4'b0???: begin
                src_valid = 1'b1;
                src_data  = bus.alu_result;
            end
            4'b1000: is_ram = 1'b1;
            4'b1010: begin
                src_valid = 1'b1;
                src_data  = {bus.level_A[DATA_W-1:HALF], bus.insn[HALF-1:0]};
            end
            4'b1100: begin
                src_valid = 1'b1;
                src_data  = {bus.level_A[HALF-1:0], bus.insn[HALF-1:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            bus_data_reg  <= '0;
            bus_valid_reg <= 1'b0;
            bus_err_reg   <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_addr_reg  <= '0;
        end else begin
            bus_valid_reg <= 1'b0;
            bus_err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.insn_valid) begin
                        if (src_valid) begin
                            bus_data_reg  <= src_data;
                            bus_valid_reg <= 1'b1;
                        end else if (is_ram) begin
                            mem_addr_reg <= bus.insn[ADDR_W-1:0];
                            mem_req_reg  <= 1'b1;
                            wait_cnt_reg <= '0;
                            state_reg    <= MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    // ack takes priority over a coincident timeout
                    if (bus.mem_ack) begin
                        bus_data_reg  <= bus.mem_rdata;
                        bus_valid_reg <= 1'b1;
                        mem_req_reg   <= 1'b0;
                        state_reg     <= IDLE;
                    end else if (TIMEOUT != 0 && wait_cnt_reg == CNT_LAST) begin
                        bus_data_reg  <= '1;
                        bus_valid_reg <= 1'b1;
                        bus_err_reg   <= 1'b1;
                        mem_req_reg   <= 1'b0;
                        state_reg     <= IDLE;
                    end else if (wait_cnt_reg != '1) begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.insn_ready = (state_reg == IDLE);
    assign bus.bus_data   = bus_data_reg;
    assign bus.bus_valid  = bus_valid_reg;
    assign bus.bus_err    = bus_err_reg;
    assign bus.mem_req    = mem_req_reg;
    assign bus.mem_addr   = mem_addr_reg;
endmodule

// File: tb/tb_bus_sequencer.sv
// Directed and randomized checks of bus_sequencer against a transaction-level model
// (DATA_W=8, ADDR_W=4, TIMEOUT=4).
module tb_bus_sequencer;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [7:0] exp_data = 8'h00;

    bus_sequencer_if #(.DATA_W(8), .ADDR_W(4)) bif ();

    bus_sequencer #(.DATA_W(8), .ADDR_W(4), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected bus result of a non-RAM instruction, from the opcode table.
    function automatic void model(input logic [7:0] i, input logic [7:0] a, input logic [7:0] c,
                                  input logic [7:0] alu, output bit is_bus, output logic [7:0] v);
        int op;
        op = int'(i) / 16;
        is_bus = 1'b1;
        v = 8'h00;
        if (op == 0)       v = c;
        else if (op < 8)   v = alu;
        else if (op == 10) v = (a & 8'hF0) | (i & 8'h0F);
        else if (op == 12) v = 8'((int'(a) % 16) * 16 + int'(i) % 16);
        else               is_bus = 1'b0;
    endfunction

    task automatic issue(input logic [7:0] i, input logic [7:0] a, input logic [7:0] c,
                         input logic [7:0] alu, input bit hold);
        bit         is_bus;
        logic [7:0] v;
        bif.insn = i; bif.level_A = a; bif.level_C = c; bif.alu_result = alu;
        bif.insn_valid = 1'b1;
        chk("ready_before", 32'(bif.insn_ready), 1);
        model(i, a, c, alu, is_bus, v);
        @(negedge clk);
        if (is_bus) exp_data = v;
        chk("bus_valid", 32'(bif.bus_valid), 32'(is_bus));
        chk("bus_data", 32'(bif.bus_data), 32'(exp_data));
        chk("bus_err", 32'(bif.bus_err), 0);
        chk("mem_req_idle", 32'(bif.mem_req), 0);
        chk("ready_after", 32'(bif.insn_ready), 1);
        if (!hold) bif.insn_valid = 1'b0;
        $display("txn insn=%02h A=%02h C=%02h alu=%02h bus_valid=%0d bus_data=%02h",
                 i, a, c, alu, bif.bus_valid, bif.bus_data);
    endtask

    // RAM read: ack offered on wait cycle d (0 = first MEM_WAIT edge) when ack_en.
    task automatic ram(input logic [7:0] i, input int d, input bit ack_en,
                       input logic [7:0] rdata, input bit hold_next, input logic [7:0] held_c);
        int         n;
        logic [7:0] expv;
        bit         experr;
        bif.insn = i;
        bif.insn_valid = 1'b1;
        chk("ram_ready_before", 32'(bif.insn_ready), 1);
        @(negedge clk);
        if (hold_next) begin
            bif.insn = 8'h00;
            bif.level_C = held_c;
        end else begin
            bif.insn_valid = 1'b0;
        end
        if (ack_en && d <= TO - 1) begin
            n = d + 1; expv = rdata; experr = 1'b0;
        end else begin
            n = TO; expv = 8'hFF; experr = 1'b1;
        end
        for (int k = 0; k < n; k++) begin
            chk("ram_mem_req", 32'(bif.mem_req), 1);
            chk("ram_ready_low", 32'(bif.insn_ready), 0);
            chk("ram_no_valid", 32'(bif.bus_valid), 0);
            chk("ram_addr", 32'(bif.mem_addr), 32'(i % 16));
            bif.mem_ack = ack_en && (k == d);
            bif.mem_rdata = bif.mem_ack ? rdata : 8'($urandom);
            @(negedge clk);
        end
        bif.mem_ack = 1'b0;
        exp_data = expv;
        chk("ram_valid", 32'(bif.bus_valid), 1);
        chk("ram_data", 32'(bif.bus_data), 32'(expv));
        chk("ram_err", 32'(bif.bus_err), 32'(experr));
        chk("ram_req_done", 32'(bif.mem_req), 0);
        chk("ram_ready_done", 32'(bif.insn_ready), 1);
        chk("ram_addr_hold", 32'(bif.mem_addr), 32'(i % 16));
        $display("txn ram insn=%02h ack_en=%0d delay=%0d bus_data=%02h bus_err=%0d",
                 i, ack_en, d, bif.bus_data, bif.bus_err);
        if (hold_next) begin
            @(negedge clk);
            exp_data = held_c;
            chk("held_valid", 32'(bif.bus_valid), 1);
            chk("held_data", 32'(bif.bus_data), 32'(held_c));
            bif.insn_valid = 1'b0;
            $display("txn held insn=00 C=%02h bus_data=%02h", held_c, bif.bus_data);
        end
    endtask

    task automatic idle(input bit ack);
        bif.insn_valid = 1'b0;
        bif.mem_ack = ack;
        bif.mem_rdata = 8'($urandom);
        @(negedge clk);
        chk("idle_valid", 32'(bif.bus_valid), 0);
        chk("idle_req", 32'(bif.mem_req), 0);
        chk("idle_data", 32'(bif.bus_data), 32'(exp_data));
        bif.mem_ack = 1'b0;
    endtask

    initial begin
        bif.insn = 8'h00; bif.insn_valid = 1'b0; bif.alu_result = 8'h00;
        bif.level_A = 8'h00; bif.level_C = 8'h00; bif.mem_ack = 1'b0; bif.mem_rdata = 8'h00;
        #1;
        chk("rst_bus_data", 32'(bif.bus_data), 0);
        chk("rst_bus_valid", 32'(bif.bus_valid), 0);
        chk("rst_bus_err", 32'(bif.bus_err), 0);
        chk("rst_mem_req", 32'(bif.mem_req), 0);
        chk("rst_mem_addr", 32'(bif.mem_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", 32'(bif.insn_ready), 1);
        idle(1'b0);

        // SC and ALU back-to-back
        issue(8'h00, 8'h00, 8'hCC, 8'h11, 1'b1);
        issue(8'h40, 8'h00, 8'h22, 8'hAA, 1'b0);
        idle(1'b0);
        // LD #i, non-bus opcode, LS #i
        issue(8'hA3, 8'h55, 8'h00, 8'h00, 1'b0);
        issue(8'hE0, 8'h12, 8'h34, 8'h56, 1'b0);
        issue(8'hC7, 8'hF0, 8'h00, 8'h00, 1'b0);
        // RAM with two wait cycles and a held SC behind it
        ram(8'h85, 2, 1'b1, 8'hF0, 1'b1, 8'h3C);
        // timeout, then ack on the last allowed cycle, then immediate ack
        ram(8'h82, 0, 1'b0, 8'h00, 1'b0, 8'h00);
        ram(8'h82, 3, 1'b1, 8'hF0, 1'b0, 8'h00);
        ram(8'h8B, 0, 1'b1, 8'h5A, 1'b0, 8'h00);
        idle(1'b1);

        // reset in the middle of a read
        bif.insn = 8'h89; bif.insn_valid = 1'b1;
        @(negedge clk);
        bif.insn_valid = 1'b0;
        @(negedge clk);
        chk("mid_req_before", 32'(bif.mem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        exp_data = 8'h00;
        chk("mid_req", 32'(bif.mem_req), 0);
        chk("mid_data", 32'(bif.bus_data), 0);
        chk("mid_valid", 32'(bif.bus_valid), 0);
        chk("mid_addr", 32'(bif.mem_addr), 0);
        chk("mid_ready", 32'(bif.insn_ready), 1);
        $display("txn reset during read");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) idle(k == 1);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            logic [7:0] ri;
            ri = 8'($urandom);
            if (ri[7:4] == 4'h8)
                ram(ri, int'($urandom_range(0, 5)), 1'($urandom), 8'($urandom),
                    1'($urandom), 8'($urandom));
            else
                issue(ri, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
            if ($urandom_range(0, 3) == 0) idle(1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
